uart_rx_cfg: RTL and testbench

Runtime-configurable UART receiver. It is the next generation of the fixed 8-bit receiver: 5–8 data bits, optional odd/even parity and 1 or 2 stop bits, selectable per frame, with 3-sample majority voting. Received frames and their per-frame error flags are buffered in a small on-chip FIFO, so the consumer in the CLK domain can drain bytes at its own pace. Overruns are reported on a sticky flag.

---
 rtl/uart_rx_pkg.sv | 27 ++
 rtl/uart_rx_fifo.sv | 50 +++++
 rtl/uart_rx_cfg.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the configurable UART receiver:
// FSM states, DATA_LEN codes, FIFO entry layout and the 3-sample vote.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP1  = 3'd4,
      S_STOP2  = 3'd5
   } rx_state_e;

   localparam logic [1:0] LEN5 = 2'b00;
   localparam logic [1:0] LEN6 = 2'b01;
   localparam logic [1:0] LEN7 = 2'b10;
   localparam logic [1:0] LEN8 = 2'b11;

   // Flag bit offsets, counted upward from the top of the data field.
   localparam int ENT_PAR_OFS = 0;
   localparam int ENT_STP_OFS = 1;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous frame FIFO; push while full is accepted only alongside a pop.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module uart_rx_fifo
   import uart_rx_pkg::*;
#(
   parameter int W     = 10,
   parameter int DEPTH = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [W-1:0]               i_wdata,
   output logic [W-1:0]               o_rdata,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic          w_wr;
   logic          w_rd;

   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_rd    = i_pop & ~o_empty;
   assign w_wr    = i_push & (~o_full | w_rd);
   assign o_rdata = r_mem[r_rptr[AW-1:0]];
   assign o_count = r_wptr - r_rptr;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + PW'(1);
         if (w_rd) r_rptr <= r_rptr + PW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5-8 data bits, optional parity,
// 1/2 stop bits, 3-sample majority vote, frames buffered in a small FIFO.
module uart_rx_cfg
   import uart_rx_pkg::*;
#(
   parameter int MAX_DATA_WIDTH = 8,
   parameter int PRESCALE_W     = 6,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          RX_IN,
   input  logic                          PAR_EN,
   input  logic                          PAR_TYP,
   input  logic                          STOP2,
   input  logic [1:0]                    DATA_LEN,
   input  logic [PRESCALE_W-1:0]         Prescale,
   input  logic                          rd_en,
   input  logic                          ovr_clr,
   output logic [MAX_DATA_WIDTH-1:0]     P_DATA,
   output logic                          data_valid,
   output logic                          Parity_Error,
   output logic                          Stop_Error,
   output logic                          overrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int EW = MAX_DATA_WIDTH + 2;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   rx_state_e               r_state, w_next_state;
   logic                    r_rx_meta, r_rx_s;
   logic [PRESCALE_W-1:0]   r_edge_cnt, r_prescale, w_half;
   logic [2:0]              r_bit_cnt, w_last_bit;
   logic [1:0]              r_smp, r_len;
   logic [7:0]              r_data;
   logic                    r_par_en, r_par_typ, r_stop2;
   logic                    r_par_err, r_stp_err, r_push;
   logic                    w_at_s0, w_at_s1, w_at_dec, w_at_end, w_maj;
   logic [EW-1:0]           w_entry, w_rdata;
   logic                    w_full, w_empty, w_drop;
   logic [CW-1:0]           w_count;
   logic [MAX_DATA_WIDTH-1:0] r_p_data;
   logic                    r_data_valid, r_par_out, r_stp_out, r_overrun;
   logic [CW-1:0]           r_fifo_count;

   assign w_half   = r_prescale >> 1;
   assign w_at_s0  = (r_edge_cnt == w_half - PRESCALE_W'(1));
   assign w_at_s1  = (r_edge_cnt == w_half);
   assign w_at_dec = (r_edge_cnt == w_half + PRESCALE_W'(1));
   assign w_at_end = (r_edge_cnt == r_prescale - PRESCALE_W'(1));
   assign w_maj    = maj3(r_smp[0], r_smp[1], r_rx_s);

   always_comb begin
      case (r_len)
         LEN5:    w_last_bit = 3'd4;
         LEN6:    w_last_bit = 3'd5;
         LEN7:    w_last_bit = 3'd6;
         LEN8:    w_last_bit = 3'd7;
         default: w_last_bit = 3'd7;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) r_state <= S_IDLE;
      else      r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (!r_rx_s) w_next_state = S_START; else w_next_state = S_IDLE;
         S_START:  if (w_at_dec && w_maj) w_next_state = S_IDLE;
                   else if (w_at_end)     w_next_state = S_DATA;
                   else                   w_next_state = S_START;
         S_DATA:   if (w_at_end && (r_bit_cnt == w_last_bit))
                      w_next_state = r_par_en ? S_PARITY : S_STOP1;
                   else
                      w_next_state = S_DATA;
         S_PARITY: if (w_at_end) w_next_state = S_STOP1; else w_next_state = S_PARITY;
         // Single-stop frames return at the decision point so the next start edge is not missed.
         S_STOP1:  if (!r_stop2 && w_at_dec)     w_next_state = S_IDLE;
                   else if (r_stop2 && w_at_end) w_next_state = S_STOP2;
                   else                          w_next_state = S_STOP1;
         S_STOP2:  if (w_at_dec) w_next_state = S_IDLE; else w_next_state = S_STOP2;
         default:  w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_rx_meta  <= 1'b1;
         r_rx_s     <= 1'b1;
         r_edge_cnt <= '0;
         r_bit_cnt  <= 3'd0;
         r_smp      <= 2'b11;
         r_data     <= 8'd0;
         r_prescale <= '0;
         r_len      <= 2'b00;
         r_par_en   <= 1'b0;
         r_par_typ  <= 1'b0;
         r_stop2    <= 1'b0;
         r_par_err  <= 1'b0;
         r_stp_err  <= 1'b0;
         r_push     <= 1'b0;
      end else begin
         r_rx_meta <= RX_IN;
         r_rx_s    <= r_rx_meta;
         r_push    <= 1'b0;
         if (r_state == S_IDLE || w_at_end) r_edge_cnt <= '0;
         else                               r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
         if (w_at_s0) r_smp[0] <= r_rx_s;
         if (w_at_s1) r_smp[1] <= r_rx_s;
         case (r_state)
            S_IDLE: if (!r_rx_s) begin
               r_prescale <= Prescale;
               r_len      <= DATA_LEN;
               r_par_en   <= PAR_EN;
               r_par_typ  <= PAR_TYP;
               r_stop2    <= STOP2;
               r_data     <= 8'd0;
               r_bit_cnt  <= 3'd0;
               r_par_err  <= 1'b0;
               r_stp_err  <= 1'b0;
            end
            S_DATA: begin
               if (w_at_dec) r_data[r_bit_cnt] <= w_maj;
               if (w_at_end) r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            // Unused upper data bits are zero, so a full-width XOR gives the frame parity.
            S_PARITY: if (w_at_dec) r_par_err <= w_maj ^ (^r_data) ^ r_par_typ;
            S_STOP1: if (w_at_dec) begin
               r_stp_err <= ~w_maj;
               r_push    <= ~r_stop2;
            end
            S_STOP2: if (w_at_dec) begin
               r_stp_err <= r_stp_err | ~w_maj;
               r_push    <= 1'b1;
            end
            default: r_push <= 1'b0;
         endcase
      end
   end

   always_comb begin
      w_entry = '0;
      w_entry[MAX_DATA_WIDTH-1:0]            = MAX_DATA_WIDTH'(r_data);
      w_entry[MAX_DATA_WIDTH + ENT_PAR_OFS]  = r_par_err;
      w_entry[MAX_DATA_WIDTH + ENT_STP_OFS]  = r_stp_err;
   end

   assign w_drop = r_push & w_full & ~rd_en;

   uart_rx_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (CLK),
      .i_rst_n (RST),
      .i_push  (r_push),
      .i_pop   (rd_en),
      .i_wdata (w_entry),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_p_data     <= '0;
         r_data_valid <= 1'b0;
         r_par_out    <= 1'b0;
         r_stp_out    <= 1'b0;
         r_overrun    <= 1'b0;
         r_fifo_count <= '0;
      end else begin
         r_data_valid <= ~w_empty;
         r_p_data     <= w_empty ? '0 : w_rdata[MAX_DATA_WIDTH-1:0];
         r_par_out    <= ~w_empty & w_rdata[MAX_DATA_WIDTH + ENT_PAR_OFS];
         r_stp_out    <= ~w_empty & w_rdata[MAX_DATA_WIDTH + ENT_STP_OFS];
         r_fifo_count <= w_count;
         if (w_drop)       r_overrun <= 1'b1;
         else if (ovr_clr) r_overrun <= 1'b0;
      end
   end

   assign P_DATA       = r_p_data;
   assign data_valid   = r_data_valid;
   assign Parity_Error = r_par_out;
   assign Stop_Error   = r_stp_out;
   assign overrun      = r_overrun;
   assign fifo_count   = r_fifo_count;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Table-driven bench for uart_rx_cfg with a scoreboard of expected FIFO entries.
module tb_uart_rx_cfg;

   logic       CLK = 1'b0;
   logic       RST, RX_IN, PAR_EN, PAR_TYP, STOP2, rd_en, ovr_clr;
   logic [1:0] DATA_LEN;
   logic [5:0] Prescale;
   logic [7:0] P_DATA;
   logic       data_valid, Parity_Error, Stop_Error, overrun;
   logic [2:0] fifo_count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] d;
      logic [1:0] len;
      logic       pen, ptyp, s2;
      int         p;
      logic       pbit, st1, st2;
      logic [7:0] exp_d;
      logic       exp_pe, exp_se;
   } vec_t;

   typedef struct {
      logic [7:0] d;
      logic       pe, se;
   } exp_t;

   vec_t vt[7];
   exp_t sb[$];

   uart_rx_cfg #(.MAX_DATA_WIDTH(8), .PRESCALE_W(6), .FIFO_DEPTH(4)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .RX_IN        (RX_IN),
      .PAR_EN       (PAR_EN),
      .PAR_TYP      (PAR_TYP),
      .STOP2        (STOP2),
      .DATA_LEN     (DATA_LEN),
      .Prescale     (Prescale),
      .rd_en        (rd_en),
      .ovr_clr      (ovr_clr),
      .P_DATA       (P_DATA),
      .data_valid   (data_valid),
      .Parity_Error (Parity_Error),
      .Stop_Error   (Stop_Error),
      .overrun      (overrun),
      .fifo_count   (fifo_count)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] d, input logic [1:0] len, input logic pen,
                               input logic ptyp, input logic s2, input int p, input logic pbit,
                               input logic st1, input logic st2, input logic pe, input logic se);
      vec_t v;
      v.d = d; v.len = len; v.pen = pen; v.ptyp = ptyp; v.s2 = s2; v.p = p;
      v.pbit = pbit; v.st1 = st1; v.st2 = st2; v.exp_d = d; v.exp_pe = pe; v.exp_se = se;
      return v;
   endfunction

   task automatic drive_bit(input logic b, input int p);
      RX_IN = b;
      repeat (p) @(negedge CLK);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic [1:0] len, input logic pen,
                             input logic ptyp, input logic s2, input int p, input logic pbit,
                             input logic st1, input logic st2);
      PAR_EN = pen; PAR_TYP = ptyp; STOP2 = s2; DATA_LEN = len; Prescale = 6'(p);
      drive_bit(1'b0, p);
      for (int i = 0; i < int'(len) + 5; i++) drive_bit(d[i], p);
      if (pen) drive_bit(pbit, p);
      drive_bit(st1, p);
      if (s2) drive_bit(st2, p);
      RX_IN = 1'b1;
   endtask

   task automatic wait_valid(input string name);
      for (int k = 0; k < 200 && !data_valid; k++) @(negedge CLK);
      chk({name, "_valid"}, 32'(data_valid), 32'd1);
   endtask

   task automatic drain_one(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         chk({name, "_sb_nonempty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         wait_valid(name);
         chk({name, "_data"}, 32'(P_DATA), 32'(e.d));
         chk({name, "_par"}, 32'(Parity_Error), 32'(e.pe));
         chk({name, "_stp"}, 32'(Stop_Error), 32'(e.se));
         rd_en = 1'b1;
         @(negedge CLK);
         rd_en = 1'b0;
         @(negedge CLK);
      end
   endtask

   initial begin
      vt[0] = mk(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0,  8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      vt[1] = mk(8'h55, 2'b10, 1'b1, 1'b0, 1'b1, 16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      vt[2] = mk(8'h1F, 2'b00, 1'b1, 1'b1, 1'b0,  8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      vt[3] = mk(8'h3C, 2'b11, 1'b1, 1'b0, 1'b1,  6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      vt[4] = mk(8'h0A, 2'b01, 1'b1, 1'b1, 1'b0, 62, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      vt[5] = mk(8'h7F, 2'b11, 1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      vt[6] = mk(8'h13, 2'b00, 1'b1, 1'b0, 1'b0, 12, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

      RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
      DATA_LEN = 2'b11; Prescale = 6'd8; rd_en = 1'b0; ovr_clr = 1'b0;
      repeat (4) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      chk("rst_valid", 32'(data_valid), 32'd0);
      chk("rst_data", 32'(P_DATA), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);

      rd_en = 1'b1;
      @(negedge CLK);
      rd_en = 1'b0;
      repeat (2) @(negedge CLK);
      chk("empty_pop_count", 32'(fifo_count), 32'd0);

      for (int i = 0; i < 7; i++) begin
         send_frame(vt[i].d, vt[i].len, vt[i].pen, vt[i].ptyp, vt[i].s2, vt[i].p,
                    vt[i].pbit, vt[i].st1, vt[i].st2);
         sb.push_back('{vt[i].exp_d, vt[i].exp_pe, vt[i].exp_se});
         repeat (2 * vt[i].p) @(negedge CLK);
         wait_valid($sformatf("vec%0d_pre", i));
         chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'd1);
         drain_one($sformatf("vec%0d", i));
         chk($sformatf("vec%0d_popped", i), 32'(data_valid), 32'd0);
      end

      // Short low pulse must be rejected as a glitch.
      Prescale = 6'd8;
      RX_IN = 1'b0;
      repeat (2) @(negedge CLK);
      RX_IN = 1'b1;
      repeat (30) @(negedge CLK);
      chk("glitch_valid", 32'(data_valid), 32'd0);
      chk("glitch_count", 32'(fifo_count), 32'd0);
      chk("glitch_state", 32'(dut.r_state), 32'd0);
      send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b1, 1'b1);
      sb.push_back('{8'h3C, 1'b0, 1'b0});
      repeat (16) @(negedge CLK);
      drain_one("glitch_next");

      // Five back-to-back frames into a 4-deep FIFO.
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 2'b11, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b1, 1'b1);
         if (i <= 4) sb.push_back('{8'(i), 1'b0, 1'b0});
      end
      repeat (20) @(negedge CLK);
      chk("ovr_count", 32'(fifo_count), 32'd4);
      chk("ovr_flag", 32'(overrun), 32'd1);
      chk("ovr_head", 32'(P_DATA), 32'h01);
      for (int i = 0; i < 4; i++) drain_one($sformatf("ovr_pop%0d", i));
      chk("ovr_empty", 32'(fifo_count), 32'd0);
      chk("ovr_sticky", 32'(overrun), 32'd1);
      ovr_clr = 1'b1;
      @(negedge CLK);
      ovr_clr = 1'b0;
      @(negedge CLK);
      chk("ovr_cleared", 32'(overrun), 32'd0);

      // Reset in the middle of the data bits of 0xFF.
      Prescale = 6'd8; DATA_LEN = 2'b11; PAR_EN = 1'b0; STOP2 = 1'b0;
      drive_bit(1'b0, 8);
      drive_bit(1'b1, 8);
      drive_bit(1'b1, 8);
      drive_bit(1'b1, 4);
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      RX_IN = 1'b1;
      RST = 1'b1;
      repeat (80) @(negedge CLK);
      chk("midrst_count", 32'(fifo_count), 32'd0);
      chk("midrst_valid", 32'(data_valid), 32'd0);
      send_frame(8'h81, 2'b11, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b1, 1'b1);
      sb.push_back('{8'h81, 1'b0, 1'b0});
      repeat (16) @(negedge CLK);
      wait_valid("midrst_next_pre");
      chk("midrst_next_count", 32'(fifo_count), 32'd1);
      drain_one("midrst_next");
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
